hazard_forward_ctrl: RTL
========================

// Module: hazard_forward_ctrl
// PURPOSE
// - Pipeline hazard controller for the 5-stage MIPS core: resolves RAW hazards for both operands of
//   the instruction in ID and registers the EX-stage forward-mux selects on ID->EX advance.
// - Detects load-use hazards and holds IF/ID for LOAD_LAT cycles via a stall FSM.
// - Handles branch flush and supplies a WB->ID regfile bypass. Keeps a saturating stall-cycle counter.
// - Sits beside the ID/EX pipeline register; drives the PC/IF-ID enables and the EX operand muxes.
// PARAMETERS
// - REG_AW     5   register-address width
// - LOAD_LAT   1   load-use stall cycles, 1..7 (1 = classic single-cycle data memory)
// - ZERO_REG   1   1: address 0 is hardwired zero, never a forwarding source
// - CNT_W      16  stall-counter width
// PORTS
// - clk          in   1       clock, rising edge
// - rst_n        in   1       asynchronous active-low reset
// - id_valid     in   1       ID holds a real instruction
// - id_rs        in   REG_AW  ID source A
// - id_rt        in   REG_AW  ID source B
// - ex_rd        in   REG_AW  EX destination
// - ex_regwrite  in   1       EX instruction writes the regfile
// - ex_memread   in   1       EX instruction is a load
// - mem_rd       in   REG_AW  MEM destination
// - mem_regwrite in   1       MEM instruction writes the regfile
// - wb_rd        in   REG_AW  WB destination
// - wb_regwrite  in   1       WB instruction writes the regfile
// - flush        in   1       branch taken/jump, kill ID
// - stall_if     out  1       hold PC and IF/ID (combinational)
// - bubble_ex    out  1       load a NOP into ID/EX (combinational)
// - fwd_a        out  2       EX mux A: 00 regfile, 10 MEM result, 01 WB result (registered)
// - fwd_b        out  2       EX mux B: same encoding (registered)
// - id_byp_a     out  1       ID read of rs takes WB write data (combinational)
// - id_byp_b     out  1       same for rt
// - stall_cnt    out  CNT_W   total stall cycles, saturating
// BEHAVIOUR
// - Reset: FSM IDLE, cnt 0, fwd_a=fwd_b=00, stall_cnt=0. All combinational outputs evaluate to 0 in IDLE with no hazard.
// - Match rule: producer P matches src s iff P_regwrite && P_rd==s && !(ZERO_REG && s==0).
// - Next selects, computed in ID for the EX cycle that follows:
//   - EX match -> 10 (the producer will be in MEM).
//   - Else MEM match -> 01 (the producer will be in WB).
//   - Else 00.
//   - The nearest producer always wins; A and B use identical priority.
// - id_byp_x = wb match on id_rs/id_rt: same-cycle regfile write/read bypass.
// - Load-use: hit = id_valid && ex_memread && EX match on rs or rt.
// - FSM IDLE:
//   - flush: bubble_ex=1; stay in IDLE.
//   - Else hit: stall_if=1, bubble_ex=1, cnt<=LOAD_LAT-1; if LOAD_LAT==1 stay IDLE, else go to STALL.
//   - Else advance: fwd_a/fwd_b <= next selects.
// - FSM STALL: stall_if=1, bubble_ex=1, cnt decrements each cycle; at cnt==1 go to IDLE. Hazards are re-evaluated in IDLE against the then-current stages.
// - Any bubble cycle (stall or flush) loads fwd_a/fwd_b <= 00.
// - Simultaneous events: flush beats stall. A flush in STALL returns to IDLE next cycle, clears cnt, stall_if=0.
// - stall_cnt: +1 on every cycle with stall_if=1; holds at all-ones.
// - Reset asserted mid-stall: immediate return to reset values, no stall carried over.
// STRUCTURE
// - Shared package (hazard_pkg):
//   - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
//   - FSM state enum {IDLE, STALL}
//   - REG_AW default
// - Sub-module: hazard_src_match (one per operand). Combinational match/priority encoder that returns the next select and the bypass bit.
// - Top level holds the FSM, the cnt down-counter, the fwd registers and stall_cnt.
// TESTING
// - EX writes r3, ID reads rs=r3 and rt=r3; MEM also writes r3 -> next cycle fwd_a=fwd_b=10 (nearest wins).
// - MEM writes r7, ID rt=r7, EX no match -> fwd_b=01, fwd_a=00. Same case with r0 and ZERO_REG=1 -> 00.
// - LOAD_LAT=3, EX load to r5, ID rs=r5 -> stall_if=1 for exactly 3 cycles, stall_cnt=3, fwd_a=00 during the bubbles.
// - Flush during cycle 2 of a LOAD_LAT=3 stall -> stall_if=0 next cycle, FSM IDLE, stall_cnt=2.
// - WB writes r9, ID rs=r9 -> id_byp_a=1 in the same cycle. rst_n low mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard / forwarding controller.
package hazard_pkg;

  // Default register-address width (32 architectural registers).
  localparam int unsigned REG_AW_DEF = 5;

  // EX operand-mux select encodings.
  localparam logic [1:0] FWD_REG = 2'b00;  // value read from the regfile in ID
  localparam logic [1:0] FWD_WB  = 2'b01;  // result of the instruction now entering WB
  localparam logic [1:0] FWD_MEM = 2'b10;  // result of the instruction now entering MEM

  // Load-use stall FSM states.
  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

endpackage : hazard_pkg

// File: rtl/hazard_src_match.sv
// Per-operand producer match and priority encoder. Given one ID source
// register it reports whether the EX producer writes it (load-use input),
// the forward select for the following EX cycle, and the WB->ID bypass bit.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = REG_AW_DEF,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_regwrite_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_regwrite_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_regwrite_i,
  output logic              ex_hit_o,
  output logic [1:0]        sel_o,
  output logic              byp_o
);

  logic src_live_s;
  logic ex_m_s;
  logic mem_m_s;
  logic wb_m_s;

  // A hardwired-zero source can never be produced by anyone.
  assign src_live_s = !(ZERO_REG && (src_i == {REG_AW{1'b0}}));

  assign ex_m_s  = src_live_s && ex_regwrite_i  && (ex_rd_i  == src_i);
  assign mem_m_s = src_live_s && mem_regwrite_i && (mem_rd_i == src_i);
  assign wb_m_s  = src_live_s && wb_regwrite_i  && (wb_rd_i  == src_i);

  // Nearest producer wins: EX (will be in MEM) over MEM (will be in WB).
  always_comb begin
    sel_o = FWD_REG;
    if (ex_m_s) begin
      sel_o = FWD_MEM;
    end else if (mem_m_s) begin
      sel_o = FWD_WB;
    end else begin
      sel_o = FWD_REG;
    end
  end

  assign ex_hit_o = ex_m_s;
  assign byp_o    = wb_m_s;

endmodule : hazard_src_match

// File: rtl/hazard_forward_ctrl.sv
// Pipeline hazard controller: load-use stall FSM, branch-flush bubbles,
// registered EX forward selects, WB->ID bypass and a saturating stall counter.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = REG_AW_DEF,
  parameter int unsigned LOAD_LAT = 1,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  input  logic              flush,
  output logic              stall_if,
  output logic              bubble_ex,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              id_byp_a,
  output logic              id_byp_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Remaining stall cycles after the detecting cycle.
  localparam logic [2:0]       CNT_LOAD = 3'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       ex_hit_a_s, ex_hit_b_s;
  logic [1:0] sel_a_s, sel_b_s;
  logic       byp_a_s, byp_b_s;
  logic       hit_s;
  logic       stall_s;
  logic       bubble_s;

  hazard_src_match #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_match_a (
    .src_i(id_rs), .ex_rd_i(ex_rd), .ex_regwrite_i(ex_regwrite),
    .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite),
    .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite),
    .ex_hit_o(ex_hit_a_s), .sel_o(sel_a_s), .byp_o(byp_a_s)
  );

  hazard_src_match #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_match_b (
    .src_i(id_rt), .ex_rd_i(ex_rd), .ex_regwrite_i(ex_regwrite),
    .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite),
    .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite),
    .ex_hit_o(ex_hit_b_s), .sel_o(sel_b_s), .byp_o(byp_b_s)
  );

  assign hit_s = id_valid && ex_memread && (ex_hit_a_s || ex_hit_b_s);

  // Next-state, stall/bubble decode and next forward selects; flush beats stall.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_s  = 1'b0;
    bubble_s = 1'b0;
    fwd_a_d  = FWD_REG;
    fwd_b_d  = FWD_REG;
    case (state_q)
      IDLE: begin
        if (flush) begin
          bubble_s = 1'b1;
        end else if (hit_s) begin
          stall_s  = 1'b1;
          bubble_s = 1'b1;
          cnt_d    = CNT_LOAD;
          if (LOAD_LAT == 1) begin
            state_d = IDLE;
          end else begin
            state_d = STALL;
          end
        end else begin
          fwd_a_d = sel_a_s;
          fwd_b_d = sel_b_s;
        end
      end
      STALL: begin
        stall_s  = 1'b1;
        bubble_s = 1'b1;
        if (flush || (cnt_q == 3'd1)) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Saturating count of cycles spent holding IF.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State, down-counter, forward selects and stall counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      fwd_a_q     <= FWD_REG;
      fwd_b_q     <= FWD_REG;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Combinational controls are forced low while reset is held.
  assign stall_if  = stall_s  & rst_n;
  assign bubble_ex = bubble_s & rst_n;
  assign id_byp_a  = byp_a_s  & rst_n;
  assign id_byp_b  = byp_b_s  & rst_n;
  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign stall_cnt = stall_cnt_q;

endmodule : hazard_forward_ctrl
